inst_dispatch_queue: RTL and testbench

//   Receiving end of the Top instruction port: accepts valid-only 27-bit words
//   {opcode[2:0], A_index[3:0], B_index[3:0], C_index[3:0], addr[11:0]}.

---
 rtl/inst_dispatch_queue.sv | 158 +++++++++++++++
 tb/tb_inst_dispatch_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_dispatch_queue.sv
// inst_dispatch_queue
//   Receives valid-only instruction words {opcode, A_idx, B_idx, C_idx, addr},
//   buffers them in a small FIFO, decodes them, and hands them one at a time
//   to the matrix execution unit over an exe_start / exe_done handshake.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   inst, inst_valid          incoming instruction word, no backpressure
//   exe_start                 one-cycle pulse, exe_* fields valid
//   exe_opcode/a/b/c/addr     decoded fields of the issued instruction
//   exe_done                  execution unit finished (honoured only in WAIT)
//   busy                      FSM not idle or FIFO non-empty
//   fifo_count                buffered entries (0..FIFO_DEPTH)
//   overflow                  sticky: a word was dropped on a full FIFO
//   illegal_op                sticky: opcode 3'b111 was popped
//   retired_cnt               completed instructions (NOPs included), wraps
module inst_dispatch_queue #(
  parameter int INST_WIDTH = 27,
  parameter int ADDR_WIDTH = 12,
  parameter int IDX_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [INST_WIDTH-1:0]         inst,
  input  logic                          inst_valid,
  output logic                          exe_start,
  output logic [2:0]                    exe_opcode,
  output logic [IDX_WIDTH-1:0]          exe_a_idx,
  output logic [IDX_WIDTH-1:0]          exe_b_idx,
  output logic [IDX_WIDTH-1:0]          exe_c_idx,
  output logic [ADDR_WIDTH-1:0]         exe_addr,
  input  logic                          exe_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          illegal_op,
  output logic [15:0]                   retired_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  logic [1:0]            state;
  logic [INST_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  push;
  logic [INST_WIDTH-1:0] head;
  logic [2:0]            head_op;

  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == DEPTH_C);
    pop        = (state == S_IDLE) && !fifo_empty;
    // A full FIFO still accepts a word when the head leaves on the same edge;
    // the write lands in the slot being vacated, whose old contents are read
    // as head before the edge.
    push       = inst_valid && (!fifo_full || pop);
    head       = mem[rd_ptr];
    head_op    = head[INST_WIDTH-1 -: 3];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= inst;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (inst_valid && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // exe_start is registered from ISSUE, so the pulse appears on the cycle
  // after the pop's following edge (pop at E1, pulse E2..E3).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      exe_start   <= 1'b0;
      exe_opcode  <= '0;
      exe_a_idx   <= '0;
      exe_b_idx   <= '0;
      exe_c_idx   <= '0;
      exe_addr    <= '0;
      illegal_op  <= 1'b0;
      retired_cnt <= '0;
    end else begin
      exe_start <= (state == S_ISSUE);
      case (state)
        S_IDLE: begin
          if (pop) begin
            if (head_op == OP_NOP) begin
              retired_cnt <= retired_cnt + 16'd1;
            end else if (head_op == OP_ILLEGAL) begin
              illegal_op <= 1'b1;
            end else begin
              exe_opcode <= head_op;
              exe_a_idx  <= head[ADDR_WIDTH+3*IDX_WIDTH-1 -: IDX_WIDTH];
              exe_b_idx  <= head[ADDR_WIDTH+2*IDX_WIDTH-1 -: IDX_WIDTH];
              exe_c_idx  <= head[ADDR_WIDTH+IDX_WIDTH-1 -: IDX_WIDTH];
              exe_addr   <= head[ADDR_WIDTH-1:0];
              state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (exe_done) begin
            retired_cnt <= retired_cnt + 16'd1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state != S_IDLE) || !fifo_empty;
  assign fifo_count = count;

endmodule

// File: tb/tb_inst_dispatch_queue.sv
// Self-checking bench for inst_dispatch_queue: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a queue-based reference model.
module tb_inst_dispatch_queue;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [26:0] inst;
  logic        inst_valid;
  logic        exe_done;
  logic        exe_start;
  logic [2:0]  exe_opcode;
  logic [3:0]  exe_a_idx, exe_b_idx, exe_c_idx;
  logic [11:0] exe_addr;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        overflow, illegal_op;
  logic [15:0] retired_cnt;

  inst_dispatch_queue #(
    .INST_WIDTH(27), .ADDR_WIDTH(12), .IDX_WIDTH(4), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rstn(rstn), .inst(inst), .inst_valid(inst_valid),
    .exe_start(exe_start), .exe_opcode(exe_opcode), .exe_a_idx(exe_a_idx),
    .exe_b_idx(exe_b_idx), .exe_c_idx(exe_c_idx), .exe_addr(exe_addr),
    .exe_done(exe_done), .busy(busy), .fifo_count(fifo_count),
    .overflow(overflow), .illegal_op(illegal_op), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  // Reference model: buffered words, plus a phase
  // 0 = idle, 1 = instruction accepted / start pending, 2 = executing.
  logic [26:0] mq[$];
  int          ph;
  bit          m_start;
  logic [2:0]  m_op;
  logic [3:0]  m_a, m_b, m_c;
  logic [11:0] m_addr;
  logic [15:0] m_ret;
  bit          m_ovf, m_ill;

  function automatic logic [26:0] mk(input int op, input int a, input int b,
                                     input int c, input int addr);
    logic [26:0] w;
    w = {op[2:0], a[3:0], b[3:0], c[3:0], addr[11:0]};
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ph = 0; m_start = 0; m_op = '0; m_a = '0; m_b = '0; m_c = '0; m_addr = '0;
    m_ret = '0; m_ovf = 0; m_ill = 0;
  endtask

  task automatic model_step();
    bit          do_pop;
    logic [26:0] hd;
    do_pop = (ph == 0) && (mq.size() != 0);
    hd = '0;
    if (do_pop) begin
      hd = mq[0];
      void'(mq.pop_front());
    end
    if (inst_valid) begin
      if (mq.size() < D) mq.push_back(inst);
      else m_ovf = 1;
    end
    m_start = (ph == 1);
    if (ph == 2) begin
      if (exe_done) begin ph = 0; m_ret = m_ret + 16'd1; end
    end else if (ph == 1) begin
      ph = 2;
    end else if (do_pop) begin
      if (hd[26:24] == 3'd0) m_ret = m_ret + 16'd1;
      else if (hd[26:24] == 3'd7) m_ill = 1;
      else begin
        m_op = hd[26:24]; m_a = hd[23:20]; m_b = hd[19:16];
        m_c = hd[15:12]; m_addr = hd[11:0]; ph = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("exe_start",   32'(exe_start),   32'(m_start));
    chk("exe_opcode",  32'(exe_opcode),  32'(m_op));
    chk("exe_a_idx",   32'(exe_a_idx),   32'(m_a));
    chk("exe_b_idx",   32'(exe_b_idx),   32'(m_b));
    chk("exe_c_idx",   32'(exe_c_idx),   32'(m_c));
    chk("exe_addr",    32'(exe_addr),    32'(m_addr));
    chk("busy",        32'(busy),        32'((ph != 0) || (mq.size() != 0)));
    chk("fifo_count",  32'(fifo_count),  32'(mq.size()));
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("illegal_op",  32'(illegal_op),  32'(m_ill));
    chk("retired_cnt", 32'(retired_cnt), 32'(m_ret));
  endtask

  // Called at a negedge; drives inputs, advances one clock, compares at the
  // following negedge.
  task automatic cycle(input bit v, input logic [26:0] w, input bit d);
    inst_valid = v; inst = w; exe_done = d;
    @(posedge clk);
    if (rstn) model_step();
    else model_reset();
    @(negedge clk);
    compare_all();
    if (exe_start === 1'b1) starts++;
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0; inst_valid = 1'b0; exe_done = 1'b0; inst = '0;
    #1;
    model_reset();
    compare_all();
    for (int i = 0; i < n; i++) cycle(0, '0, 0);
    rstn = 1'b1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (busy === 1'b1 && k < budget) begin
      cycle(0, '0, 1);
      k++;
    end
    chk("drain_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; inst_valid = 1'b0; exe_done = 1'b0; inst = '0;
    model_reset();
    @(negedge clk);

    // Reset state
    do_reset(5);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_start", 32'(exe_start), 32'd0);

    // Single op: pulse after E2, fields decoded
    cycle(1, mk(1, 2, 3, 4, 12'h0A5), 0);
    cycle(0, '0, 0);
    chk("single_no_early_start", 32'(exe_start), 32'd0);
    cycle(0, '0, 0);
    chk("single_start", 32'(exe_start), 32'd1);
    chk("single_a", 32'(exe_a_idx), 32'd2);
    chk("single_b", 32'(exe_b_idx), 32'd3);
    chk("single_c", 32'(exe_c_idx), 32'd4);
    chk("single_addr", 32'(exe_addr), 32'h0A5);
    cycle(0, '0, 0);
    chk("single_start_one_cycle", 32'(exe_start), 32'd0);
    cycle(0, '0, 0);
    cycle(0, '0, 1);
    chk("single_retired", 32'(retired_cnt), 32'd1);
    chk("single_busy", 32'(busy), 32'd0);
    chk("single_fields_held", 32'(exe_addr), 32'h0A5);

    // Overflow: six pushes while execution stalls
    do_reset(2);
    for (int i = 0; i < 6; i++) cycle(1, mk(1 + i, i, i + 1, i + 2, 16 * i), 0);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    drain(60);
    chk("ovf_retired", 32'(retired_cnt), 32'd5);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // NOP / illegal / regular
    do_reset(2);
    starts = 0;
    cycle(1, mk(0, 1, 1, 1, 1), 0);
    cycle(1, mk(7, 2, 2, 2, 2), 0);
    cycle(1, mk(2, 3, 3, 3, 3), 0);
    drain(30);
    chk("nop_starts", 32'(starts), 32'd1);
    chk("nop_illegal", 32'(illegal_op), 32'd1);
    chk("nop_retired", 32'(retired_cnt), 32'd2);
    chk("nop_opcode", 32'(exe_opcode), 32'd2);

    // Full FIFO with a pop on the same edge as a push
    do_reset(2);
    for (int i = 0; i < 5; i++) cycle(1, mk(3, i, i, i, i), 0);
    chk("fp_full", 32'(fifo_count), 32'd4);
    cycle(0, '0, 1);
    cycle(1, mk(4, 9, 9, 9, 12'h999), 0);
    chk("fp_count", 32'(fifo_count), 32'd4);
    chk("fp_overflow", 32'(overflow), 32'd0);
    drain(60);
    chk("fp_retired", 32'(retired_cnt), 32'd6);
    chk("fp_last_addr", 32'(exe_addr), 32'h999);

    // Reset while waiting on an instruction
    do_reset(2);
    cycle(1, mk(0, 0, 0, 0, 0), 0);
    cycle(1, mk(3, 5, 6, 7, 12'h123), 0);
    cycle(0, '0, 0);
    cycle(0, '0, 0);
    cycle(0, '0, 0);
    chk("rw_pre_retired", 32'(retired_cnt), 32'd1);
    chk("rw_pre_busy", 32'(busy), 32'd1);
    do_reset(5);
    chk("rw_start", 32'(exe_start), 32'd0);
    chk("rw_count", 32'(fifo_count), 32'd0);
    chk("rw_retired", 32'(retired_cnt), 32'd0);
    starts = 0;
    cycle(1, mk(4, 1, 2, 3, 12'hABC), 0);
    drain(30);
    chk("rw_after_starts", 32'(starts), 32'd1);
    chk("rw_after_retired", 32'(retired_cnt), 32'd1);
    chk("rw_after_addr", 32'(exe_addr), 32'hABC);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset(2);
      else cycle($urandom_range(0, 99) < 45, 27'($urandom), $urandom_range(0, 99) < 30);
    end
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
